regf_wb_sched: RTL and testbench

// - Write-back scheduler for the 32x32 register file: shares its single write port between NREQ

---
 rtl/regf_pkg.sv | 11 +
 rtl/regf_wb_sched_rr_arb.sv | 45 ++++
 rtl/regf_wb_sched.sv | 73 +++++++
 tb/tb_regf_wb_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regf_pkg.sv
// Shared register-file constants and write-back requester identifiers.
package regf_pkg;
   localparam int NREG = 32;
   localparam int RW   = 5;
   localparam int DW   = 32;

   typedef enum logic [0:0] {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_e;
endpackage

// File: rtl/regf_wb_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after the pointer.
module rr_arb #(
   parameter int NREQ = 2,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [NREQ-1:0] i_valid,
   input  logic            i_accept,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_gidx
);
   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_gidx;
   logic            w_found;

   always_comb begin
      int unsigned idx;
      idx     = 0;
      w_grant = '0;
      w_gidx  = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(r_ptr) + i) % NREQ;
         if (!w_found && i_valid[idx]) begin
            w_grant[idx] = 1'b1;
            w_gidx       = PW'(idx);
            w_found      = 1'b1;
         end
      end
   end

   // Grant is forced low while reset is held so no transfer is signalled during reset.
   assign o_grant = i_rst_n ? w_grant : '0;
   assign o_gidx  = w_gidx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_accept) begin
         r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
   end
endmodule

// File: rtl/regf_wb_sched.sv
// Write-back scheduler: arbitrates requesters onto the register-file write port and
// tracks destinations with writes in flight for RAW hazard stalls.
module regf_wb_sched
   import regf_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_iss_valid,
   input  logic [RW-1:0]      i_iss_reg,
   input  logic [RW-1:0]      i_rd0,
   input  logic [RW-1:0]      i_rd1,
   output logic               o_stall,
   input  logic [NREQ-1:0]    i_req_valid,
   input  logic [NREQ*RW-1:0] i_req_reg,
   input  logic [NREQ*DW-1:0] i_req_val,
   output logic [NREQ-1:0]    o_req_ready,
   output logic               o_wb_en,
   output logic [RW-1:0]      o_wb_reg,
   output logic [DW-1:0]      o_wb_val
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: requester k transfers on a rising edge where i_req_valid[k] & o_req_ready[k];
   // requesters hold valid/reg/val stable until that edge, ready only ever asserts with valid.
   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_gidx;
   logic            w_accept;
   logic [RW-1:0]   w_sel_reg;
   logic [DW-1:0]   w_sel_val;
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_req_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant),
      .o_gidx   (w_gidx)
   );

   assign o_req_ready = w_grant;
   assign w_accept    = |(w_grant & i_req_valid);
   assign w_sel_reg   = i_req_reg[int'(w_gidx)*RW +: RW];
   assign w_sel_val   = i_req_val[int'(w_gidx)*DW +: DW];

   // Clear before set so a newer issue to the same index stays outstanding.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_accept) w_busy_nxt[w_sel_reg] = 1'b0;
      if (i_iss_valid) w_busy_nxt[i_iss_reg] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy   <= '0;
         o_wb_en  <= 1'b0;
         o_wb_reg <= '0;
         o_wb_val <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         o_wb_en <= w_accept;
         if (w_accept) begin
            o_wb_reg <= w_sel_reg;
            o_wb_val <= w_sel_val;
         end
      end
   end

   assign o_stall = r_busy[i_rd0] | r_busy[i_rd1];
endmodule

// File: tb/tb_regf_wb_sched.sv
// Directed bench for regf_wb_sched: reset, single write, contention, hazards, set/clear, idle.
module tb_regf_wb_sched;
   import regf_pkg::*;
   localparam int NREQ = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               iss_valid;
   logic [RW-1:0]      iss_reg, rd0, rd1;
   logic               stall;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*RW-1:0] req_reg;
   logic [NREQ*DW-1:0] req_val;
   logic [NREQ-1:0]    req_ready;
   logic               wb_en;
   logic [RW-1:0]      wb_reg;
   logic [DW-1:0]      wb_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regf_wb_sched #(.NREQ(NREQ)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_iss_valid (iss_valid),
      .i_iss_reg   (iss_reg),
      .i_rd0       (rd0),
      .i_rd1       (rd1),
      .o_stall     (stall),
      .i_req_valid (req_valid),
      .i_req_reg   (req_reg),
      .i_req_val   (req_val),
      .o_req_ready (req_ready),
      .o_wb_en     (wb_en),
      .o_wb_reg    (wb_reg),
      .o_wb_val    (wb_val)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [RW-1:0] r, input logic [DW-1:0] v);
      req_reg[k*RW +: RW] = r;
      req_val[k*DW +: DW] = v;
   endtask

   initial begin
      rst_n = 1'b0; iss_valid = 1'b0; iss_reg = '0; rd0 = '0; rd1 = '0;
      req_valid = '0; req_reg = '0; req_val = '0;
      #2;
      chk("rst_wb_en", 32'(wb_en), 32'h0);
      chk("rst_wb_reg", 32'(wb_reg), 32'h0);
      chk("rst_wb_val", wb_val, 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      tick(); tick();
      rst_n = 1'b1;

      // Single write from requester 0
      req_valid = 2'b01; set_req(0, 5'd5, 32'hDEADBEEF);
      #1 chk("single_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("single_wb_en", 32'(wb_en), 32'h1);
      chk("single_wb_reg", 32'(wb_reg), 32'h5);
      chk("single_wb_val", wb_val, 32'hDEADBEEF);
      tick();
      chk("single_idle_en", 32'(wb_en), 32'h0);
      chk("single_hold_reg", 32'(wb_reg), 32'h5);
      chk("single_hold_val", wb_val, 32'hDEADBEEF);

      // Pointer now 1: lone requester 1 still granted, then reset mid-transfer
      req_valid = 2'b10; set_req(1, 5'd9, 32'h99);
      #1 chk("mid_ready", 32'(req_ready), 32'h2);
      tick();
      chk("mid_wb_reg", 32'(wb_reg), 32'h9);
      set_req(1, 5'd10, 32'h1010);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en", 32'(wb_en), 32'h0);
      chk("mid_rst_reg", 32'(wb_reg), 32'h0);
      chk("mid_rst_val", wb_val, 32'h0);
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("mid_rst_hold_en", 32'(wb_en), 32'h0);
      rst_n = 1'b1; req_valid = 2'b00;
      tick();
      chk("mid_rst_lost", 32'(wb_en), 32'h0);

      // Contention: pointer back at 0 -> grants 0,1,0,1
      req_valid = 2'b11; set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hB2);
      for (int c = 0; c < 4; c++) begin
         #1 chk("cont_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         chk("cont_wb_reg", 32'(wb_reg), (c % 2 == 0) ? 32'h1 : 32'h2);
         chk("cont_wb_val", wb_val, (c % 2 == 0) ? 32'hA1 : 32'hB2);
      end
      req_valid = 2'b00;

      // Hazard on reg 7; no bypass of same-cycle issue
      iss_valid = 1'b1; iss_reg = 5'd7; rd0 = 5'd7;
      #1 chk("haz_no_bypass", 32'(stall), 32'h0);
      tick();
      iss_valid = 1'b0;
      chk("haz_rd0", 32'(stall), 32'h1);
      rd0 = 5'd0; rd1 = 5'd7;
      #1 chk("haz_rd1", 32'(stall), 32'h1);
      rd0 = 5'd8; rd1 = 5'd6;
      #1 chk("haz_other", 32'(stall), 32'h0);
      rd1 = 5'd7; req_valid = 2'b10; set_req(1, 5'd7, 32'h77);
      #1 chk("haz_ready", 32'(req_ready), 32'h2);
      chk("haz_still_busy", 32'(stall), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("haz_cleared", 32'(stall), 32'h0);
      chk("haz_wb_reg", 32'(wb_reg), 32'h7);
      chk("haz_wb_val", wb_val, 32'h77);
      rd0 = 5'd0; rd1 = 5'd0;

      // Simultaneous set and clear of reg 3: set wins
      iss_valid = 1'b1; iss_reg = 5'd3;
      tick();
      req_valid = 2'b01; set_req(0, 5'd3, 32'h33);
      #1 chk("sc_ready", 32'(req_ready), 32'h1);
      tick();
      iss_valid = 1'b0; req_valid = 2'b00; rd0 = 5'd3;
      #1 chk("sc_set_wins", 32'(stall), 32'h1);
      chk("sc_wb_reg", 32'(wb_reg), 32'h3);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      chk("sc_clear", 32'(stall), 32'h0);

      // Index 0 is scoreboarded like any other register
      rd0 = 5'd0;
      iss_valid = 1'b1; iss_reg = 5'd0;
      tick();
      iss_valid = 1'b0;
      chk("reg0_busy", 32'(stall), 32'h1);

      // Idle: nothing changes; pointer stays at 1
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_wb_en", 32'(wb_en), 32'h0);
         chk("idle_wb_reg", 32'(wb_reg), 32'h3);
         chk("idle_busy0", 32'(stall), 32'h1);
      end
      req_valid = 2'b11; set_req(0, 5'd0, 32'hC0); set_req(1, 5'd4, 32'hC4);
      #1 chk("idle_ptr", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      chk("idle_after_reg", 32'(wb_reg), 32'h4);
      chk("idle_after_val", wb_val, 32'hC4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
